// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] NOP_INSTR = 32'h0;
  localparam logic [PC_W-1:0] RESET_PC  = 32'h0;

  typedef enum logic [1:0] {
    NPC_SEQ,
    NPC_HOLD,
    NPC_JUMP,
    NPC_BRANCH
  } npc_sel_t;

  // Redirect targets are always forced onto a word boundary.
  function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory port, hazard/redirect inputs, IF/ID outputs.
interface fetch_if;
  import fetch_pkg::*;

  logic [PC_W-1:0] pc_o;
  logic [31:0]     instr_i;
  logic            stall_i;
  logic            jump_i;
  logic [PC_W-1:0] jump_pc_i;
  logic            branch_i;
  logic [PC_W-1:0] branch_pc_i;
  logic [31:0]     ifid_instr_o;
  logic [PC_W-1:0] ifid_pc4_o;
  logic            ifid_valid_o;
  logic            end_o;
  logic            misalign_o;
  logic [31:0]     fetch_cnt_o;

  modport master (
    output pc_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o, end_o, misalign_o, fetch_cnt_o,
    input  instr_i, stall_i, jump_i, jump_pc_i, branch_i, branch_pc_i
  );

  modport slave (
    input  pc_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o, end_o, misalign_o, fetch_cnt_o,
    output instr_i, stall_i, jump_i, jump_pc_i, branch_i, branch_pc_i
  );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register with hold enable and async active-low reset.
module pc_reg
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= RESET_PC;
    else if (!hold)
      pc <= load_val;
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC sequencing, redirects, stalls and the IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int MEM_DEPTH = 32
) (
  input  logic   clk_i,
  input  logic   rst_i,
  fetch_if.master bus
);

  localparam logic [PC_W-1:0] FETCH_LIMIT = PC_W'(4 * MEM_DEPTH);

  npc_sel_t        npc_sel;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] next_pc;
  logic            past_end;
  logic            stall_hold;
  logic            misalign_hit;

  assign pc_plus4   = pc + 32'd4;
  assign past_end   = (pc >= FETCH_LIMIT);
  assign stall_hold = bus.stall_i && !bus.branch_i;

  always_comb begin
    npc_sel = NPC_SEQ;
    if (bus.branch_i)
      npc_sel = NPC_BRANCH;
    else if (bus.stall_i)
      npc_sel = NPC_HOLD;
    else if (bus.jump_i)
      npc_sel = NPC_JUMP;
    else if (past_end)
      npc_sel = NPC_HOLD;
  end

  always_comb begin
    next_pc = pc;
    case (npc_sel)
      NPC_SEQ:    next_pc = pc_plus4;
      NPC_JUMP:   next_pc = align_word(bus.jump_pc_i);
      NPC_BRANCH: next_pc = align_word(bus.branch_pc_i);
      default:    next_pc = pc;
    endcase
  end

  // Only redirects that actually take effect can flag a misaligned target.
  assign misalign_hit = ((npc_sel == NPC_BRANCH) && (bus.branch_pc_i[1:0] != 2'b00)) ||
                        ((npc_sel == NPC_JUMP)   && (bus.jump_pc_i[1:0]   != 2'b00));

  pc_reg u_pc_reg (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .hold     (npc_sel == NPC_HOLD),
    .load_val (next_pc),
    .pc       (pc)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bus.ifid_instr_o <= NOP_INSTR;
      bus.ifid_pc4_o   <= '0;
      bus.ifid_valid_o <= 1'b0;
      bus.fetch_cnt_o  <= '0;
      bus.misalign_o   <= 1'b0;
    end else begin
      if (misalign_hit)
        bus.misalign_o <= 1'b1;
      if (npc_sel == NPC_SEQ) begin
        bus.ifid_instr_o <= bus.instr_i;
        bus.ifid_pc4_o   <= pc_plus4;
        bus.ifid_valid_o <= 1'b1;
        bus.fetch_cnt_o  <= bus.fetch_cnt_o + 32'd1;
      end else if (!stall_hold) begin
        // Redirect or fetch past the window: insert a bubble.
        bus.ifid_instr_o <= NOP_INSTR;
        bus.ifid_pc4_o   <= '0;
        bus.ifid_valid_o <= 1'b0;
      end
    end
  end

  assign bus.pc_o  = pc;
  assign bus.end_o = past_end;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a reference model feeding an expected-result queue.
module tb_fetch_stage;

  localparam int DEPTH = 32;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        end_f;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] mem [DEPTH];
  exp_t        exp_q [$];

  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid, m_mis;

  fetch_if bus ();

  fetch_stage #(.MEM_DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.instr_i = ((bus.pc_o >> 2) < DEPTH) ? mem[bus.pc_o[6:2]] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_mis = 0; m_cnt = 0;
    exp_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"},    bus.pc_o, 32'h0);
    chk({tag, "_instr"}, bus.ifid_instr_o, 32'h0);
    chk({tag, "_pc4"},   bus.ifid_pc4_o, 32'h0);
    chk({tag, "_valid"}, {31'h0, bus.ifid_valid_o}, 32'h0);
    chk({tag, "_end"},   {31'h0, bus.end_o}, 32'h0);
    chk({tag, "_mis"},   {31'h0, bus.misalign_o}, 32'h0);
    chk({tag, "_cnt"},   bus.fetch_cnt_o, 32'h0);
  endtask

  // One clock of stimulus; the model's prediction is queued, then checked after the edge.
  task automatic step(input string tag, input logic b, input logic [31:0] bpc,
                      input logic s, input logic j, input logic [31:0] jpc);
    exp_t e;
    bus.branch_i = b; bus.branch_pc_i = bpc;
    bus.stall_i = s;  bus.jump_i = j; bus.jump_pc_i = jpc;
    if (b) begin
      if (bpc[1:0] != 0) m_mis = 1;
      m_pc = {bpc[31:2], 2'b00}; m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (s) begin
    end else if (j) begin
      if (jpc[1:0] != 0) m_mis = 1;
      m_pc = {jpc[31:2], 2'b00}; m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (m_pc < 4 * DEPTH) begin
      m_instr = mem[m_pc >> 2]; m_pc4 = m_pc + 4; m_valid = 1;
      m_cnt = m_cnt + 1; m_pc = m_pc + 4;
    end else begin
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
    e.end_f = (m_pc >= 4 * DEPTH); e.mis = m_mis; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, "_pc"},    bus.pc_o, e.pc);
    chk({tag, "_instr"}, bus.ifid_instr_o, e.instr);
    chk({tag, "_pc4"},   bus.ifid_pc4_o, e.pc4);
    chk({tag, "_valid"}, {31'h0, bus.ifid_valid_o}, {31'h0, e.valid});
    chk({tag, "_end"},   {31'h0, bus.end_o}, {31'h0, e.end_f});
    chk({tag, "_mis"},   {31'h0, bus.misalign_o}, {31'h0, e.mis});
    chk({tag, "_cnt"},   bus.fetch_cnt_o, e.cnt);
  endtask

  task automatic seq(input string tag);
    step(tag, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = 32'(k + 1);
    bus.stall_i = 0; bus.jump_i = 0; bus.jump_pc_i = 0;
    bus.branch_i = 0; bus.branch_pc_i = 0;
    rst_n = 1'b0;
    model_reset();
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Five unstalled fetches.
    for (int k = 1; k <= 5; k++) begin
      seq("seq");
      chk("seq_instr_k", bus.ifid_instr_o, 32'(k));
      chk("seq_pc4_k", bus.ifid_pc4_o, 32'(4 * k));
    end
    chk("seq_cnt5", bus.fetch_cnt_o, 32'd5);

    async_reset("arst1");

    // Stall at pc 8.
    seq("pre_stall");
    seq("pre_stall");
    chk("stall_at_pc", bus.pc_o, 32'h8);
    step("stall", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step("stall", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("stall_pc_frozen", bus.pc_o, 32'h8);
    chk("stall_cnt_frozen", bus.fetch_cnt_o, 32'd2);
    chk("stall_instr_frozen", bus.ifid_instr_o, 32'd2);
    seq("stall_rel");
    chk("stall_rel_instr", bus.ifid_instr_o, 32'd3);

    // A jump held off by a stall must not flag its misaligned target.
    step("stall_jump", 1'b0, 32'h0, 1'b1, 1'b1, 32'h23);
    chk("stall_jump_mis", {31'h0, bus.misalign_o}, 32'h0);
    seq("to_pc10");
    chk("jump_at_pc", bus.pc_o, 32'h10);

    step("jump", 1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
    chk("jump_pc", bus.pc_o, 32'h40);
    chk("jump_bubble", {31'h0, bus.ifid_valid_o}, 32'h0);
    seq("post_jump");
    chk("post_jump_instr", bus.ifid_instr_o, 32'd17);
    chk("post_jump_pc4", bus.ifid_pc4_o, 32'h44);

    step("prio", 1'b1, 32'h4, 1'b1, 1'b1, 32'h60);
    chk("prio_pc", bus.pc_o, 32'h4);
    chk("prio_bubble", {31'h0, bus.ifid_valid_o}, 32'h0);

    // Run off the end of the window.
    for (int k = 0; k < 31; k++) seq("run");
    chk("end_pc", bus.pc_o, 32'h80);
    chk("end_flag", {31'h0, bus.end_o}, 32'h1);
    seq("end_hold");
    seq("end_hold");
    chk("end_pc_hold", bus.pc_o, 32'h80);
    chk("end_valid", {31'h0, bus.ifid_valid_o}, 32'h0);
    step("end_branch", 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("end_cleared", {31'h0, bus.end_o}, 32'h0);

    step("mis_jump", 1'b0, 32'h0, 1'b0, 1'b1, 32'h22);
    chk("mis_pc", bus.pc_o, 32'h20);
    chk("mis_set", {31'h0, bus.misalign_o}, 32'h1);
    for (int k = 0; k < 10; k++) seq("mis_sticky");
    chk("mis_sticky10", {31'h0, bus.misalign_o}, 32'h1);

    async_reset("arst2");
    seq("after_rst");
    chk("after_rst_instr", bus.ifid_instr_o, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core: owns the program counter, drives the word-aligned byte address into the combinational instruction memory, and captures the returned instruction plus PC+4 into the IF/ID pipeline register. It sits upstream of the instruction memory's address input and downstream of its instruction output, and feeds the decode stage. Stalls from the hazard unit, jump redirects from ID, and branch redirects from EX/MEM all resolve here.

## Interface
- MEM_DEPTH, 32: instruction memory depth in words; the fetch window is byte addresses 0 .. 4*MEM_DEPTH-4.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- pc_o  out  32  current PC; goes to the instruction memory address input (byte address, word index = pc/4).
- instr_i  in  32  instruction returned combinationally for pc_o in the same cycle.
- stall_i  in  1  load-use hazard; hold the PC and IF/ID.
- jump_i  in  1  jump/jal resolved in ID.
- jump_pc_i  in  32  jump target.
- branch_i  in  1  taken branch resolved in EX/MEM.
- branch_pc_i  in  32  branch target.
- ifid_instr_o  out  32  IF/ID instruction.
- ifid_pc4_o  out  32  IF/ID PC+4.
- ifid_valid_o  out  1  IF/ID holds a real fetched instruction; 0 means bubble.
- end_o  out  1  PC has run past the fetch window.
- misalign_o  out  1  sticky flag; set when a redirect target had bits [1:0] ≠ 0.
- fetch_cnt_o  out  32  count of valid instructions loaded into IF/ID.

## Operation
- Reset values:
  - pc_o = 0
  - ifid_instr_o = 0 (NOP)
  - ifid_pc4_o = 0
  - ifid_valid_o = 0
  - end_o = 0
  - misalign_o = 0
  - fetch_cnt_o = 0
- Each cycle resolves exactly one action, in priority order branch > stall > jump > sequential:
  - Branch: PC ← branch_pc_i. IF/ID ← NOP, valid 0, pc4 0. stall_i is ignored that cycle.
  - Stall: PC, IF/ID and fetch_cnt_o all hold.
  - Jump: PC ← jump_pc_i. IF/ID ← NOP, valid 0, pc4 0. This squashes the single instruction fetched behind the jump.
  - Sequential, PC inside the fetch window: PC ← PC+4. IF/ID ← {instr_i, PC+4}, valid 1. fetch_cnt_o increments.
  - Sequential, PC ≥ 4*MEM_DEPTH: PC holds. IF/ID ← NOP, valid 0. Counter holds.
- end_o is combinational: (pc_o ≥ 4*MEM_DEPTH). A later redirect back into the window clears it.
- Redirect targets are loaded with bits [1:0] forced to 0.
  - If the raw target had bits [1:0] ≠ 0, misalign_o sets and stays set until reset.
  - A jump ignored because of a stall does not set misalign_o.
- A PC+4 overflow at 32'hFFFFFFFC wraps to 0. This is unreachable inside the window; it is defined only for completeness.
- fetch_cnt_o wraps modulo 2^32.

## Timing
- Fetch latency: an instruction at address A appears on ifid_instr_o one clock edge after pc_o = A with no stall.
- First valid IF/ID is after the first rising edge following reset release: instr[0], pc4 = 4.
- Redirect penalty:
  - Jump: 1 bubble.
  - Branch: 1 bubble in IF/ID. Flushing ID/EX and later stages is done outside this block.
- stall_i and the redirect inputs are sampled only at the rising edge and have no combinational path to any output except through pc_o. end_o depends on pc_o only.
- Reset asserted mid-operation clears all state immediately (asynchronous). The first fetch after release is from address 0.

## Structure
- Shared package fetch_pkg holds:
  - NOP_INSTR = 32'h0
  - PC_W = 32
  - RESET_PC = 32'h0
  - the next-PC select enum: NPC_SEQ, NPC_HOLD, NPC_JUMP, NPC_BRANCH
- One sub-module, pc_reg: the PC register with async active-low reset, hold enable, and load value.
- The IF/ID register, priority encoder, counter and flags live in fetch_stage.

## Test plan
- Reset, then 5 unstalled cycles with memory words k+1 at word k → ifid_instr_o sequence 1,2,3,4,5; ifid_pc4_o 4,8,12,16,20; fetch_cnt_o = 5.
- stall_i high for 2 cycles when pc_o = 8 → pc_o, IF/ID and fetch_cnt_o frozen for 2 cycles; on release, instr at 8 is captured next.
- jump_i with jump_pc_i = 0x40 when pc_o = 0x10 → next cycle pc_o = 0x40 and ifid_valid_o = 0; the following cycle ifid_instr_o = mem[16], pc4 = 0x44.
- branch_i (target 0x04), jump_i and stall_i all high in one cycle → pc_o = 0x04, bubble in IF/ID; jump and stall have no effect.
- Run sequentially to pc_o = 0x80 with MEM_DEPTH = 32 → end_o = 1, pc_o holds, valid stays 0; a branch to 0x0 clears end_o.
- jump_pc_i = 0x22 → pc_o = 0x20, misalign_o = 1 and still 1 after 10 cycles; async reset mid-run (between clock edges) → all outputs return to their reset values immediately.
